sqnorm_sched: RTL and testbench

//  Scheduler that shares one poly_small_sqnorm unit between NREQ requesters (keygen f/g sources).

---
 rtl/sqnorm_pkg.sv | 22 ++
 rtl/sqnorm_sched_rr_arbiter.sv | 29 ++
 rtl/sqnorm_sched.sv | 194 +++++++++++++++++++
 tb/tb_sqnorm_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqnorm_pkg.sv
// Shared types and width helpers for the sqnorm scheduler.
package sqnorm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic int f_bit(input int logn);
    return (logn == 9) ? 7 : 6;
  endfunction

  function automatic int s_bit(input int logn);
    return (logn == 9) ? 21 : 20;
  endfunction

endpackage

// File: rtl/sqnorm_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority restarts just above the last winner.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  // Pointer kept as a mask of requesters strictly above the previous winner.
  logic [NREQ-1:0] mask_reg;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick_src;

  assign masked   = req & mask_reg;
  assign pick_src = (|masked) ? masked : req;
  assign grant    = pick_src & (~pick_src + NREQ'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '1;
    end else if (advance) begin
      mask_reg <= ~(grant | (grant - NREQ'(1)));
    end
  end

endmodule

// File: rtl/sqnorm_sched.sv
// Shares one poly_small_sqnorm unit between NREQ coefficient sources, one job at a time.
// Define SQNORM_SCHED_BOUND_EN to add sum_bound/res_reject over one result per requester.
module sqnorm_sched
  import sqnorm_pkg::*;
#(
  parameter int LOGN     = 9,
  parameter int NREQ     = 2,
  parameter int F_BIT    = f_bit(LOGN),
  parameter int S_BIT    = s_bit(LOGN),
  parameter int ENA_GAP  = 2,
  parameter int MAX_WAIT = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_start,
  output logic [NREQ-1:0]       req_grant,
  input  logic [NREQ-1:0]       coef_valid,
  input  logic [NREQ*F_BIT-1:0] coef_data,
  output logic [NREQ-1:0]       coef_ready,
  output logic [NREQ-1:0]       res_valid,
  output logic [S_BIT-1:0]      res_data,
  output logic                  res_err,
  output logic                  sq_ena,
  output logic                  sq_f_valid,
  output logic [F_BIT-1:0]      sq_f,
  input  logic                  sq_s_valid,
  input  logic [S_BIT-1:0]      sq_s,
`ifdef SQNORM_SCHED_BOUND_EN
  input  logic [S_BIT:0]        sum_bound,
  output logic                  res_reject,
`endif
  output logic                  busy
);

  localparam int N  = 1 << LOGN;
  localparam int CW = LOGN + 1;
  localparam int WW = 11;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  grant_reg, arb_grant;
  logic [F_BIT-1:0] coef_reg, coef_sel;
  logic [S_BIT-1:0] res_reg;
  logic             err_reg;
  logic [CW-1:0]    coef_cnt_reg;
  logic [WW-1:0]    wait_cnt_reg;
  logic             start, coef_hit, last_coef, timeout, gap_end;

  assign start     = (state_reg == ST_IDLE) && (|req_start);
  assign coef_hit  = |(coef_valid & grant_reg);
  assign last_coef = (coef_cnt_reg == CW'(N - 1));
  assign timeout   = (wait_cnt_reg >= WW'(MAX_WAIT));
  assign gap_end   = (wait_cnt_reg >= WW'(ENA_GAP - 1));

  always_comb begin
    coef_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_reg[i]) coef_sel = coef_sel | coef_data[i*F_BIT +: F_BIT];
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_start),
    .advance (start),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_grant  = '0;
    coef_ready = '0;
    res_valid  = '0;
    res_data   = '0;
    res_err    = 1'b0;
    sq_ena     = 1'b0;
    sq_f_valid = 1'b0;
    sq_f       = '0;
    busy       = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (|req_start) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        req_grant  = grant_reg;
        sq_ena     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        req_grant  = grant_reg;
        sq_ena     = 1'b1;
        coef_ready = grant_reg;
        if (coef_hit) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        req_grant  = grant_reg;
        sq_ena     = 1'b1;
        sq_f_valid = 1'b1;
        sq_f       = coef_reg;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        req_grant = grant_reg;
        sq_ena    = 1'b1;
        // An ack in the same cycle as the timeout still wins.
        if (sq_s_valid)   state_next = last_coef ? ST_DONE : ST_FETCH;
        else if (timeout) state_next = ST_DONE;
      end
      ST_DONE: begin
        req_grant  = grant_reg;
        sq_ena     = 1'b1;
        res_valid  = grant_reg;
        res_data   = res_reg;
        res_err    = err_reg;
        state_next = ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // wait_cnt_reg doubles as the GAP length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg    <= '0;
      coef_reg     <= '0;
      res_reg      <= '0;
      err_reg      <= 1'b0;
      coef_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) grant_reg <= arb_grant;
        ST_GRANT: begin
          coef_cnt_reg <= '0;
          wait_cnt_reg <= '0;
        end
        ST_FETCH: if (coef_hit) coef_reg <= coef_sel;
        ST_ISSUE: wait_cnt_reg <= '0;
        ST_WAIT: begin
          if (sq_s_valid) begin
            coef_cnt_reg <= coef_cnt_reg + CW'(1);
            if (last_coef) begin
              res_reg <= sq_s;
              err_reg <= 1'b0;
            end
          end else if (timeout) begin
            res_reg <= '0;
            err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WW'(1);
          end
        end
        ST_DONE:  wait_cnt_reg <= '0;
        ST_GAP:   wait_cnt_reg <= wait_cnt_reg + WW'(1);
        default:  ;
      endcase
    end
  end

`ifdef SQNORM_SCHED_BOUND_EN
  logic [S_BIT:0]  sum_reg, sum_next;
  logic [NREQ-1:0] fin_reg, fin_next;
  logic            all_fin;

  assign sum_next   = sum_reg + {1'b0, res_reg};
  assign fin_next   = fin_reg | grant_reg;
  assign all_fin    = &fin_next;
  assign res_reject = (state_reg == ST_DONE) && !err_reg && all_fin && (sum_next > sum_bound);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
      fin_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      if (err_reg || all_fin) begin
        sum_reg <= '0;
        fin_reg <= '0;
      end else begin
        sum_reg <= sum_next;
        fin_reg <= fin_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sqnorm_sched.sv
// Directed bench for sqnorm_sched with behavioural requesters and squared-norm unit.
`timescale 1ns/1ps
module tb_sqnorm_sched;
  import sqnorm_pkg::*;

  localparam int LOGN     = 9;
  localparam int NREQ     = 2;
  localparam int F_BIT    = f_bit(LOGN);
  localparam int S_BIT    = s_bit(LOGN);
  localparam int ENA_GAP  = 2;
  localparam int MAX_WAIT = 2000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_start = '0;
  logic [NREQ-1:0]       req_grant;
  logic [NREQ-1:0]       coef_valid = '0;
  logic [NREQ*F_BIT-1:0] coef_data = '0;
  logic [NREQ-1:0]       coef_ready;
  logic [NREQ-1:0]       res_valid;
  logic [S_BIT-1:0]      res_data;
  logic                  res_err;
  logic                  sq_ena;
  logic                  sq_f_valid;
  logic [F_BIT-1:0]      sq_f;
  logic                  sq_s_valid = 1'b0;
  logic [S_BIT-1:0]      sq_s = '0;
  logic                  busy;
`ifdef SQNORM_SCHED_BOUND_EN
  logic [S_BIT:0]        sum_bound = (S_BIT+1)'(6000);
  logic                  res_reject;
`endif

  always #5 clk = ~clk;

  sqnorm_sched #(
    .LOGN(LOGN), .NREQ(NREQ), .F_BIT(F_BIT), .S_BIT(S_BIT),
    .ENA_GAP(ENA_GAP), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_start  (req_start),
    .req_grant  (req_grant),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .sq_ena     (sq_ena),
    .sq_f_valid (sq_f_valid),
    .sq_f       (sq_f),
    .sq_s_valid (sq_s_valid),
    .sq_s       (sq_s),
`ifdef SQNORM_SCHED_BOUND_EN
    .sum_bound  (sum_bound),
    .res_reject (res_reject),
`endif
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requesters: each job token raises req_start; coefficient k is pat_a (even k) or pat_b (odd k).
  int tok [NREQ];
  int seen [NREQ];
  int idx [NREQ];
  int gap [NREQ];
  bit cons [NREQ];
  int pat_a [NREQ];
  int pat_b [NREQ];
  bit gaps_en = 1'b0;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tok[i] = 0; pat_a[i] = 0; pat_b[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (tok[i] != seen[i]) begin
        seen[i] = tok[i];
        req_start[i] = 1'b1;
        idx[i] = 0;
        cons[i] = 1'b0;
        gap[i] = 0;
      end
      if (req_grant[i]) req_start[i] = 1'b0;
      if (cons[i]) begin
        cons[i] = 1'b0;
        idx[i]++;
        gap[i] = gaps_en ? int'($urandom_range(0, 5)) : 0;
      end
      if (gap[i] > 0) begin
        coef_valid[i] = 1'b0;
        gap[i]--;
      end else begin
        coef_valid[i] = 1'b1;
      end
      coef_data[i*F_BIT +: F_BIT] = F_BIT'((idx[i] % 2 == 0) ? pat_a[i] : pat_b[i]);
      if (coef_valid[i] && coef_ready[i]) cons[i] = 1'b1;
    end
  end

  // Unit model: acks each strobe one cycle later with the running sum of squares.
  int drop_idx = -1;
  int strobe_cnt = 0;
  bit pending = 1'b0;
  logic [S_BIT-1:0] acc = '0;

  always @(negedge clk) begin
    int v;
    sq_s_valid = 1'b0;
    if (pending) begin
      sq_s_valid = 1'b1;
      sq_s = acc;
      pending = 1'b0;
    end
    if (!sq_ena || !rst_n) begin
      acc = '0;
      strobe_cnt = 0;
      pending = 1'b0;
    end else if (sq_f_valid) begin
      if (strobe_cnt != drop_idx) begin
        v = $signed(sq_f);
        acc = acc + S_BIT'(v * v);
        pending = 1'b1;
      end
      strobe_cnt++;
    end
  end

  typedef struct {
    int who;
    longint data;
    int err;
    int rej;
  } res_t;
  res_t res_q[$];

  always @(negedge clk) begin
    res_t r;
    if (res_valid != '0) begin
      r.who = -1;
      for (int i = 0; i < NREQ; i++)
        if (res_valid[i]) r.who = (r.who == -1) ? i : 99;
      r.data = longint'(res_data);
      r.err = int'(res_err);
`ifdef SQNORM_SCHED_BOUND_EN
      r.rej = int'(res_reject);
`else
      r.rej = 0;
`endif
      res_q.push_back(r);
      $display("result who=%0d data=%0d err=%0d rej=%0d", r.who, r.data, r.err, r.rej);
    end
  end

  // Protocol monitor plus shortest sq_ena low run between jobs.
  int viol = 0;
  int low_run = 0;
  int min_low = 1000;
  bit seen_high = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen_high = 1'b0;
      low_run = 0;
    end else begin
      if (!$onehot0(req_grant)) viol++;
      if ((res_valid & ~req_grant) != '0) viol++;
      if ((coef_ready & ~req_grant) != '0) viol++;
      if (sq_f_valid && !sq_ena) viol++;
      if (sq_ena) begin
        if (seen_high && low_run > 0 && low_run < min_low) min_low = low_run;
        seen_high = 1'b1;
        low_run = 0;
      end else if (seen_high) begin
        low_run++;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    int a0, b0, a1, b1;
    bit gaps;
    int drop;
    int nres;
    int w0, d0, e0, r0;
    int w1, d1, e1, r1;
  } job_t;

  task automatic run_job(input job_t v, input string tag);
    int base;
    int cyc;
    pat_a[0] = v.a0; pat_b[0] = v.b0;
    pat_a[1] = v.a1; pat_b[1] = v.b1;
    gaps_en = v.gaps;
    drop_idx = v.drop;
    base = res_q.size();
    min_low = 1000;
    for (int i = 0; i < NREQ; i++)
      if (v.req[i]) tok[i]++;
    cyc = 0;
    while (res_q.size() - base < v.nres && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    while (busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, longint'(cyc >= 20000), 0);
    repeat (5) @(negedge clk);
    check({tag, "_nres"}, res_q.size() - base, v.nres);
    for (int k = 0; k < v.nres; k++) begin
      if (base + k < res_q.size()) begin
        check($sformatf("%s_who%0d", tag, k), res_q[base+k].who, (k == 0) ? v.w0 : v.w1);
        check($sformatf("%s_data%0d", tag, k), res_q[base+k].data, (k == 0) ? v.d0 : v.d1);
        check($sformatf("%s_err%0d", tag, k), res_q[base+k].err, (k == 0) ? v.e0 : v.e1);
`ifdef SQNORM_SCHED_BOUND_EN
        check($sformatf("%s_rej%0d", tag, k), res_q[base+k].rej, (k == 0) ? v.r0 : v.r1);
`endif
      end
    end
  endtask

  job_t vec [5];

  initial begin
    job_t v;
    int base;
    int cyc;

    vec[0] = '{2'b11, -3, -3, 2, 2, 1'b0, -1, 2, 0, 4608, 0, 0, 1, 2048, 0, 1};
    vec[1] = '{2'b01, 1, 1, 0, 0, 1'b0, -1, 1, 0, 512, 0, 0, 0, 0, 0, 0};
    vec[2] = '{2'b10, 0, 0, 5, -5, 1'b0, 100, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    vec[3] = '{2'b01, 5, -7, 0, 0, 1'b0, -1, 1, 0, 18944, 0, 0, 0, 0, 0, 0};
    vec[4] = '{2'b01, 63, -63, 0, 0, 1'b1, -1, 1, 0, 2032128, 0, 0, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          longint'({req_grant, coef_ready, res_valid, res_data, res_err, sq_ena, sq_f_valid, sq_f}), 0);
    check("reset_busy", longint'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int j = 0; j < 5; j++) begin
      run_job(vec[j], $sformatf("job%0d", j));
      if (j == 0) check("gap_sq_ena_low", min_low, ENA_GAP + 1);
    end

    // Reset in the middle of a job: everything drops at once, no result, clean restart.
    pat_a[0] = 1; pat_b[0] = 1;
    gaps_en = 1'b0;
    drop_idx = -1;
    tok[0]++;
    cyc = 0;
    while (idx[0] < 300 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reset_reach300", longint'(cyc >= 5000), 0);
    base = res_q.size();
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          longint'({req_grant, coef_ready, res_valid, res_data, res_err, sq_ena, sq_f_valid, sq_f}), 0);
    check("mid_reset_busy", longint'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_reset_no_result", res_q.size() - base, 0);
    run_job(vec[1], "restart");

    check("protocol_violations", viol, 0);

`ifdef SQNORM_SCHED_BOUND_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sum_bound = (S_BIT+1)'(7000);
    repeat (2) @(negedge clk);
    v = vec[0];
    v.r1 = 0;
    run_job(v, "bound7000");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
